wire_logic_pipe: RTL and testbench

Parametrised, pipelined successor to the team's single-bit combinational wire/logic demonstrator. Each transaction carries three WIDTH-bit operand vectors A, B and D and a mode selecting one of four bitwise three-input functions. Each transaction passes through a stallable register pipeline of STAGES slices under a valid/ready handshake. The output carries the result vector, its population count and a running count of completed output transactions. It sits between stimulus sources and checkers in the team's logic-study benches and is the first block in this area with clocked, back-pressured behaviour.

---
 rtl/wire_logic_pkg.sv | 43 ++++
 rtl/wire_logic_stage.sv | 36 +++
 rtl/wire_logic_pipe.sv | 66 ++++++
 tb/tb_wire_logic_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wire_logic_pkg.sv
// Shared types and helpers for the pipelined three-input bitwise logic block.
// Functions operate on a 64-bit maximum width; callers zero-extend and truncate.
package wire_logic_pkg;

  localparam int COUNT_W = 16;
  localparam int MAX_W   = 64;
  localparam int POP_W   = 7;

  typedef enum logic [1:0] {
    MODE_AO   = 2'd0,
    MODE_OA   = 2'd1,
    MODE_XOR3 = 2'd2,
    MODE_MAJ  = 2'd3
  } logic_mode_e;

  function automatic logic [MAX_W-1:0] logic_apply(
    input logic_mode_e      mode,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic [MAX_W-1:0] d
  );
    logic [MAX_W-1:0] r;
    r = '0;
    case (mode)
      MODE_AO:   r = (a & b) | d;
      MODE_OA:   r = (a | b) & d;
      MODE_XOR3: r = a ^ b ^ d;
      MODE_MAJ:  r = (a & b) | (a & d) | (b & d);
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_W; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/wire_logic_stage.sv
// One pipeline slice: valid + data register with valid/ready on both sides.
// Latency 1 cycle; ready to upstream when empty or when the downstream takes the held item.
module wire_logic_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // An empty slice always loads, so bubbles collapse under a downstream stall.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/wire_logic_pipe.sv
// Evaluates a mode-selected bitwise (A,B,D) function and carries the result through STAGES slices.
// Result on valid_o STAGES cycles after acceptance; stalls hold outputs, ready_o follows ready_i combinationally.
module wire_logic_pipe
  import wire_logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [1:0]                 mode_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  input  logic [WIDTH-1:0]           d_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           e_o,
  output logic [$clog2(WIDTH+1)-1:0] ones_o,
  output logic [COUNT_W-1:0]         count_o
);

  localparam int ONES_W = $clog2(WIDTH+1);

  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [WIDTH-1:0] dat [STAGES+1];
  logic [COUNT_W-1:0] count_q;

  // Function is evaluated once at the input; slices only carry the result.
  assign vld[0] = valid_i;
  assign dat[0] = WIDTH'(logic_apply(logic_mode_e'(mode_i),
                                     MAX_W'(a_i), MAX_W'(b_i), MAX_W'(d_i)));
  assign ready_o = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    wire_logic_stage #(
      .W(WIDTH)
    ) u_stage (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .in_valid (vld[k]),
      .in_ready (rdy[k]),
      .in_data  (dat[k]),
      .out_valid(vld[k+1]),
      .out_ready(rdy[k+1]),
      .out_data (dat[k+1])
    );
  end

  assign rdy[STAGES] = ready_i;
  assign valid_o     = vld[STAGES];
  assign e_o         = dat[STAGES];
  assign ones_o      = ONES_W'(popcount(MAX_W'(dat[STAGES])));
  assign count_o     = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (vld[STAGES] && ready_i) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_wire_logic_pipe.sv
// Directed self-checking bench for wire_logic_pipe (WIDTH=8, STAGES=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_wire_logic_pipe;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  mode_i;
  logic [7:0]  a_i, b_i, d_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  e_o;
  logic [3:0]  ones_o;
  logic [15:0] count_o;

  int errors = 0;
  int checks = 0;

  wire_logic_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .mode_i (mode_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .d_i    (d_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .e_o    (e_o),
    .ones_o (ones_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    valid_i = v;
    mode_i  = m;
    a_i     = a;
    b_i     = b;
    d_i     = d;
  endtask

  initial begin
    logic [7:0] mode_exp [4];
    mode_exp[0] = 8'hF8;
    mode_exp[1] = 8'hE0;
    mode_exp[2] = 8'h96;
    mode_exp[3] = 8'hE8;

    // Reset state
    rst_ni  = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    chk("rst_valid_o", valid_o, 0);
    chk("rst_e_o",     e_o,     0);
    chk("rst_ones_o",  ones_o,  0);
    chk("rst_count_o", count_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("rst_ready_o", ready_o, 1);

    // Single transaction, mode 0: (F0&CC)|01 = C1
    drive(1'b1, 2'd0, 8'hF0, 8'hCC, 8'h01);
    tick();
    drive(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    chk("single_not_yet_valid", valid_o, 0);
    tick();
    chk("single_valid_o", valid_o, 1);
    chk("single_e_o",     e_o,     8'hC1);
    chk("single_ones_o",  ones_o,  3);
    chk("single_count_pre", count_o, 0);
    tick();
    chk("single_count_post", count_o, 1);
    chk("single_drained",    valid_o, 0);

    // All four modes streamed back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 8'hAA, 8'hCC, 8'hF0);
      tick();
      if (i >= 1) begin
        chk($sformatf("mode%0d_valid", i - 1), valid_o, 1);
        chk($sformatf("mode%0d_e_o", i - 1),   e_o,     mode_exp[i-1]);
      end
    end
    drive(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    tick();
    chk("mode3_valid", valid_o, 1);
    chk("mode3_e_o",   e_o,     mode_exp[3]);
    tick();
    chk("modes_count", count_o, 5);

    // Back-pressure with three transactions
    ready_i = 1'b0;
    drive(1'b1, 2'd2, 8'h01, 8'h00, 8'h00);
    chk("bp_ready_1", ready_o, 1);
    tick();
    drive(1'b1, 2'd2, 8'h02, 8'h00, 8'h00);
    chk("bp_ready_2", ready_o, 1);
    tick();
    drive(1'b1, 2'd2, 8'h04, 8'h00, 8'h00);
    chk("bp_ready_full", ready_o, 0);
    chk("bp_valid_o",    valid_o, 1);
    chk("bp_e_o",        e_o,     8'h01);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_ready", ready_o, 0);
      chk("bp_hold_valid", valid_o, 1);
      chk("bp_hold_e_o",   e_o,     8'h01);
      chk("bp_hold_ones",  ones_o,  1);
    end
    ready_i = 1'b1;
    #1;
    chk("bp_release_ready", ready_o, 1);
    tick();
    drive(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    chk("bp_out2_valid", valid_o, 1);
    chk("bp_out2_e_o",   e_o,     8'h02);
    tick();
    chk("bp_out3_valid", valid_o, 1);
    chk("bp_out3_e_o",   e_o,     8'h04);
    tick();
    chk("bp_drained", valid_o, 0);
    chk("bp_count",   count_o, 8);

    // Fill the pipeline, then 10 cycles of simultaneous accept and output
    ready_i = 1'b0;
    drive(1'b1, 2'd2, 8'h10, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'd2, 8'h11, 8'h00, 8'h00);
    tick();
    chk("full_ready_o", ready_o, 0);
    ready_i = 1'b1;
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 2'd2, 8'(8'h12 + j), 8'h00, 8'h00);
      #1;
      chk("sim_ready_o", ready_o, 1);
      chk("sim_valid_o", valid_o, 1);
      chk("sim_e_o",     e_o,     8'(8'h10 + j));
      tick();
    end
    drive(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    ready_i = 1'b0;
    #1;
    chk("sim_count",     count_o, 18);
    chk("sim_still_full", ready_o, 0);
    chk("sim_head_e_o",  e_o,     8'h1A);
    ready_i = 1'b1;
    tick();
    tick();
    chk("sim_drain_count", count_o, 20);

    // Preload count to 0xFFFE, then wrap through 0xFFFF to 0x0000
    drive(1'b1, 2'd3, 8'h5A, 8'h3C, 8'h0F);
    for (int j = 0; j < 16'hFFFE - 20; j++) begin
      tick();
    end
    drive(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    chk("wrap_valid_idle", valid_o, 0);
    chk("wrap_count_fffe", count_o, 16'hFFFE);
    drive(1'b1, 2'd2, 8'hA5, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'd2, 8'h5A, 8'h00, 8'h00);
    tick();
    drive(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    tick();
    chk("wrap_count_ffff", count_o, 16'hFFFF);
    tick();
    chk("wrap_count_0000", count_o, 16'h0000);
    tick();

    // Reset asserted with two transactions in flight
    drive(1'b1, 2'd2, 8'h0F, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'd2, 8'h1F, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'd2, 8'h3F, 8'h00, 8'h00);
    tick();
    drive(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    ready_i = 1'b0;
    chk("mid_count_pre", count_o, 1);
    chk("mid_valid_pre", valid_o, 1);
    chk("mid_e_o_pre",   e_o,     8'h1F);
    chk("mid_ones_pre",  ones_o,  5);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid_o", valid_o, 0);
    chk("mid_rst_count_o", count_o, 0);
    chk("mid_rst_e_o",     e_o,     0);
    chk("mid_rst_ones_o",  ones_o,  0);
    tick();
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("post_rst_no_stale", valid_o, 0);
    end
    chk("post_rst_ready_o", ready_o, 1);
    chk("post_rst_count_o", count_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
